// File: rtl/clk_div_prog.sv
// Programmable integer clock divider. It produces a registered divided clock
// and a clock-enable strobe. The divide ratio can be changed at run time with
// a load/ack/err handshake. A new ratio waits as "pending" until the current
// out_clk period ends, so the output never shows a runt pulse.
module clk_div_prog #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             out_clk,
    output logic             ce,
    output logic             div_ack,
    output logic             div_err,
    output logic             div_busy
);

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_N = CNT_W'(2);

    // High-phase length ceil(n/2). It is written as n/2 + lsb so that it
    // cannot overflow at the largest legal ratio.
    function automatic logic [CNT_W-1:0] half_ceil(input logic [CNT_W-1:0] n);
        return (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
    endfunction

    logic [CNT_W-1:0] n_r, h_r, cnt_r, pend_r;
    logic             busy_r;

    logic [CNT_W-1:0] n_nx, h_nx, cnt_nx, pend_nx;
    logic             busy_nx, out_nx, ce_nx, ack_nx, err_nx;
    logic             last;
    logic [CNT_W-1:0] cnt_wrap;
    logic             req_bad, req_ok;

    assign last     = (cnt_r == n_r - ONE);
    assign cnt_wrap = last ? '0 : cnt_r + ONE;
    // A request is refused while another ratio is pending. This also covers
    // the cycle in which that pending ratio is being applied.
    assign req_bad  = div_load && ((div_val < MIN_N) || busy_r);
    assign req_ok   = div_load && !req_bad;

    // Next-state logic: phase counter, ratio switch-over and request handling.
    always_comb begin
        n_nx    = n_r;
        h_nx    = h_r;
        cnt_nx  = cnt_r;
        pend_nx = pend_r;
        busy_nx = busy_r;
        out_nx  = 1'b0;
        ce_nx   = 1'b0;
        ack_nx  = req_ok;
        err_nx  = req_bad;
        if (en) begin
            cnt_nx = cnt_wrap;
            out_nx = (cnt_wrap < h_r);
            ce_nx  = (cnt_wrap == '0);
            if (busy_r && last) begin
                // Period boundary: the new ratio takes over and its first
                // period starts with this wrap to zero.
                n_nx    = pend_r;
                h_nx    = half_ceil(pend_r);
                busy_nx = 1'b0;
                out_nx  = 1'b1;
                ce_nx   = 1'b1;
            end
        end else if (busy_r) begin
            // While idle there is no period in progress, so a pending ratio
            // is applied at once.
            n_nx    = pend_r;
            h_nx    = half_ceil(pend_r);
            cnt_nx  = pend_r - ONE;
            busy_nx = 1'b0;
        end else begin
            // Park the counter at N-1 so that the first enabled cycle wraps
            // to 0 and starts a high phase.
            cnt_nx = n_r - ONE;
        end
        if (req_ok) begin
            pend_nx = div_val;
            busy_nx = 1'b1;
        end
    end

    // State and output registers. Every output is a direct flop output.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            n_r      <= DEF_N;
            h_r      <= half_ceil(DEF_N);
            cnt_r    <= DEF_N - ONE;
            pend_r   <= '0;
            busy_r   <= 1'b0;
            out_clk  <= 1'b0;
            ce       <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
        end else begin
            n_r      <= n_nx;
            h_r      <= h_nx;
            cnt_r    <= cnt_nx;
            pend_r   <= pend_nx;
            busy_r   <= busy_nx;
            out_clk  <= out_nx;
            ce       <= ce_nx;
            div_ack  <= ack_nx;
            div_err  <= err_nx;
        end
    end

    assign div_busy = busy_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (CNT_W=8, DEF_DIV=2). Status vectors are
// packed as {out_clk, ce, div_ack, div_err, div_busy}.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rstn, en, div_load;
    logic [7:0] div_val;
    logic       out_clk, ce, div_ack, div_err, div_busy;

    int checks   = 0;
    int failures = 0;

    clk_div_prog #(.CNT_W(8), .DEF_DIV(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .div_load (div_load),
        .div_val  (div_val),
        .out_clk  (out_clk),
        .ce       (ce),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .div_busy (div_busy)
    );

    always #5 clk = ~clk;

    // Output invariants, checked on every falling edge once out of reset.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if ((div_ack && div_err) || (ce && !out_clk)) begin
                $display("FAIL invariant: ack=%0b err=%0b ce=%0b out_clk=%0b", div_ack, div_err, ce, out_clk);
                failures++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record out_clk and ce over n cycles; bit i holds cycle i.
    task automatic capture(input int n, output logic [15:0] ov, output logic [15:0] cv);
        ov = '0;
        cv = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            ov[i] = out_clk;
            cv[i] = ce;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
        tick(); tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b00000) begin
            $display("FAIL reset: got %b want 00000", {out_clk, ce, div_ack, div_err, div_busy});
            failures++;
        end
    endtask

    task automatic test_div2();
        logic [15:0] ov, cv;
        rstn = 1'b1; en = 1'b1;
        capture(8, ov, cv);
        checks++;
        if (ov[7:0] !== 8'h55) begin
            $display("FAIL div2_out: got %h want 55", ov[7:0]); failures++;
        end
        checks++;
        if (cv[7:0] !== 8'h55) begin
            $display("FAIL div2_ce: got %h want 55", cv[7:0]); failures++;
        end
    endtask

    task automatic test_load5();
        logic [15:0] ov, cv;
        div_load = 1'b1; div_val = 8'd5;
        tick();
        div_load = 1'b0;
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b11101) begin
            $display("FAIL load5_ack: got %b want 11101", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b00001) begin
            $display("FAIL load5_busy: got %b want 00001", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b11000) begin
            $display("FAIL load5_apply: got %b want 11000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        capture(10, ov, cv);
        checks++;
        if (ov[9:0] !== 10'h273) begin
            $display("FAIL load5_out: got %h want 273", ov[9:0]); failures++;
        end
        checks++;
        if (cv[9:0] !== 10'h210) begin
            $display("FAIL load5_ce: got %h want 210", cv[9:0]); failures++;
        end
    endtask

    task automatic test_load_err();
        logic [15:0] ov, cv;
        div_load = 1'b1; div_val = 8'd1;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b10010) begin
            $display("FAIL err_val1: got %b want 10010", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        div_val = 8'd0;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b10010) begin
            $display("FAIL err_val0: got %b want 10010", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        div_load = 1'b0;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b00000) begin
            $display("FAIL err_clear: got %b want 00000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        capture(5, ov, cv);
        checks++;
        if ({ov[4:0], cv[4:0]} !== {5'h0E, 5'h02}) begin
            $display("FAIL err_keep_n5: got out=%h ce=%h want out=0e ce=02", ov[4:0], cv[4:0]); failures++;
        end
    endtask

    task automatic test_busy_reject();
        logic [15:0] ov, cv;
        logic [4:0]  exp_wait [3];
        exp_wait[0] = 5'b10001; exp_wait[1] = 5'b00001; exp_wait[2] = 5'b00001;
        tick();
        div_load = 1'b1; div_val = 8'd8;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b11101) begin
            $display("FAIL load8_ack: got %b want 11101", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        div_val = 8'd4;
        tick();
        div_load = 1'b0;
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b10011) begin
            $display("FAIL load4_busy_err: got %b want 10011", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({out_clk, ce, div_ack, div_err, div_busy} !== exp_wait[i]) begin
                $display("FAIL load8_wait%0d: got %b want %b", i, {out_clk, ce, div_ack, div_err, div_busy}, exp_wait[i]); failures++;
            end
        end
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b11000) begin
            $display("FAIL load8_apply: got %b want 11000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        capture(16, ov, cv);
        checks++;
        if ({ov, cv} !== {16'h8787, 16'h8080}) begin
            $display("FAIL div8_wave: got out=%h ce=%h want out=8787 ce=8080", ov, cv); failures++;
        end
    endtask

    task automatic test_collision_en_drop();
        logic [15:0] ov, cv;
        div_load = 1'b1; div_val = 8'd6;
        tick();
        div_load = 1'b0;
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b10101) begin
            $display("FAIL load6_ack: got %b want 10101", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (div_busy !== 1'b1) begin
            $display("FAIL load6_still_busy: got %b want 1", div_busy); failures++;
        end
        // A request landing on the apply cycle is refused.
        div_load = 1'b1; div_val = 8'd3;
        tick();
        div_load = 1'b0;
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b11010) begin
            $display("FAIL collide: got %b want 11010", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        tick(); tick();
        checks++;
        if ({out_clk, ce} !== 2'b10) begin
            $display("FAIL n6_cnt2: got %b want 10", {out_clk, ce}); failures++;
        end
        en = 1'b0;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b00000) begin
            $display("FAIL en_drop: got %b want 00000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        tick();
        en = 1'b1;
        tick();
        checks++;
        if ({out_clk, ce} !== 2'b11) begin
            $display("FAIL reenable: got %b want 11", {out_clk, ce}); failures++;
        end
        capture(6, ov, cv);
        checks++;
        if ({ov[5:0], cv[5:0]} !== {6'h23, 6'h20}) begin
            $display("FAIL div6_wave: got out=%h ce=%h want out=23 ce=20", ov[5:0], cv[5:0]); failures++;
        end
    endtask

    task automatic test_idle_apply();
        logic [15:0] ov, cv;
        div_load = 1'b1; div_val = 8'd2;
        tick();
        div_load = 1'b0;
        en = 1'b0;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b00000) begin
            $display("FAIL idle_apply: got %b want 00000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        en = 1'b1;
        tick();
        checks++;
        if ({out_clk, ce} !== 2'b11) begin
            $display("FAIL idle_first: got %b want 11", {out_clk, ce}); failures++;
        end
        capture(4, ov, cv);
        checks++;
        if ({ov[3:0], cv[3:0]} !== {4'b1010, 4'b1010}) begin
            $display("FAIL idle_div2: got out=%b ce=%b want 1010/1010", ov[3:0], cv[3:0]); failures++;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ov, cv;
        div_load = 1'b1; div_val = 8'd7;
        tick();
        div_load = 1'b0;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b11000) begin
            $display("FAIL load7_apply: got %b want 11000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        div_load = 1'b1; div_val = 8'd3;
        tick();
        div_load = 1'b0;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b10001) begin
            $display("FAIL pend3: got %b want 10001", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        rstn = 1'b0; div_load = 1'b1; div_val = 8'd5;
        tick();
        checks++;
        if ({out_clk, ce, div_ack, div_err, div_busy} !== 5'b00000) begin
            $display("FAIL reset_mid: got %b want 00000", {out_clk, ce, div_ack, div_err, div_busy}); failures++;
        end
        rstn = 1'b1; div_load = 1'b0;
        tick();
        checks++;
        if ({out_clk, ce, div_busy} !== 3'b110) begin
            $display("FAIL post_reset_first: got %b want 110", {out_clk, ce, div_busy}); failures++;
        end
        capture(4, ov, cv);
        checks++;
        if ({ov[3:0], cv[3:0]} !== {4'b1010, 4'b1010}) begin
            $display("FAIL post_reset_div2: got out=%b ce=%b want 1010/1010", ov[3:0], cv[3:0]); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_load5();
        test_load_err();
        test_busy_reject();
        test_collision_en_drop();
        test_idle_apply();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
